// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal transmit FIFO.
// The producer handshakes words into a circular buffer with tx_rdy/tx_ack.
// A framing FSM pops one word per frame and shifts it out LSB first.
// Each frame is: start bit, data bits, optional parity bit, then stop bits.
// A word waiting at the end of a stop bit starts the next frame immediately.
module uart_tx_fifo #(
    parameter int    DATA_BITS    = 8,
    parameter string PARITY       = "NONE",
    parameter int    STOP_BIT     = 1,
    parameter int    CLKS_PER_BIT = 1,
    parameter int    FIFO_DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_BITS-1:0]         tx_data,
    input  logic                         tx_rdy,
    output logic                         tx_ack,
    output logic                         tx,
    output logic                         busy,
    output logic                         full,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam bit HAS_PARITY = (PARITY != "NONE");
    localparam bit ODD_PARITY = (PARITY == "ODD");

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BIT - 1);
    localparam logic [LVL_W-1:0]  DEPTH     = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY_BIT,
        STOP
    } state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;

    state_t               state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;

    logic accept;
    logic pop;
    logic baud_last;
    logic stop_done;

    // A word is taken only when the previous ack has already been seen,
    // which spaces writes from a producer that holds tx_rdy high.
    assign full      = (fifo_level == DEPTH);
    assign accept    = tx_rdy && !tx_ack && !full;
    assign baud_last = (baud_cnt == BAUD_LAST);
    assign stop_done = (state == STOP) && baud_last && (bit_cnt == STOP_LAST);
    assign pop       = (fifo_level != '0) && ((state == IDLE) || stop_done);

    // FIFO storage; stale entries are harmless because the pointers gate them
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers, occupancy and the one-cycle write acknowledge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            tx_ack     <= 1'b0;
        end else begin
            tx_ack <= accept;
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Capture the head word and its parity at pop, then shift it out LSB first
    always_ff @(posedge clk) begin
        if (pop) begin
            shift   <= mem[rd_ptr];
            par_bit <= (^mem[rd_ptr]) ^ ODD_PARITY;
        end else if ((state == DATA) && baud_last && (bit_cnt != DATA_LAST)) begin
            shift <= shift >> 1;
        end
    end

    // Framing FSM; tx and busy are registered so the line never glitches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (pop) begin
                        state <= START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= DATA;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (HAS_PARITY) begin
                                state <= PARITY_BIT;
                                tx    <= par_bit;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                PARITY_BIT: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= STOP;
                        tx       <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            if (pop) begin
                                state <= START;
                                tx    <= 1'b0;
                            end else begin
                                state <= IDLE;
                                tx    <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: six instances in different configurations share one clock.
// A queue-based model predicts tx, busy, tx_ack, fifo_level and full.
// It is checked against every instance on every falling edge.
// Literal checks pin the model on the directed scenarios.
module tb_uart_tx_fifo;

    localparam int N = 6;
    // Per-instance configuration: data bits, parity (0 none, 1 odd, 2 even), stop bits, clocks per bit
    localparam int DB  [N] = '{8, 8, 8, 8, 8, 5};
    localparam int PM  [N] = '{1, 2, 0, 1, 0, 0};
    localparam int SB  [N] = '{1, 1, 1, 2, 1, 1};
    localparam int CPB [N] = '{1, 1, 1, 1, 16, 3};
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [8:0] data   [N];
    logic       rdy    [N];
    logic       ack    [N];
    logic       tx_o   [N];
    logic       busy_o [N];
    logic       full_o [N];
    logic [2:0] lvl    [N];

    int vectors;
    int miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_BITS(8), .PARITY("ODD"), .STOP_BIT(1), .CLKS_PER_BIT(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .tx_data(data[0][7:0]), .tx_rdy(rdy[0]), .tx_ack(ack[0]),
        .tx(tx_o[0]), .busy(busy_o[0]), .full(full_o[0]), .fifo_level(lvl[0]));
    uart_tx_fifo #(.DATA_BITS(8), .PARITY("EVEN"), .STOP_BIT(1), .CLKS_PER_BIT(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .tx_data(data[1][7:0]), .tx_rdy(rdy[1]), .tx_ack(ack[1]),
        .tx(tx_o[1]), .busy(busy_o[1]), .full(full_o[1]), .fifo_level(lvl[1]));
    uart_tx_fifo #(.DATA_BITS(8), .PARITY("NONE"), .STOP_BIT(1), .CLKS_PER_BIT(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .tx_data(data[2][7:0]), .tx_rdy(rdy[2]), .tx_ack(ack[2]),
        .tx(tx_o[2]), .busy(busy_o[2]), .full(full_o[2]), .fifo_level(lvl[2]));
    uart_tx_fifo #(.DATA_BITS(8), .PARITY("ODD"), .STOP_BIT(2), .CLKS_PER_BIT(1), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .rst(rst), .tx_data(data[3][7:0]), .tx_rdy(rdy[3]), .tx_ack(ack[3]),
        .tx(tx_o[3]), .busy(busy_o[3]), .full(full_o[3]), .fifo_level(lvl[3]));
    uart_tx_fifo #(.DATA_BITS(8), .PARITY("NONE"), .STOP_BIT(1), .CLKS_PER_BIT(16), .FIFO_DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .tx_data(data[4][7:0]), .tx_rdy(rdy[4]), .tx_ack(ack[4]),
        .tx(tx_o[4]), .busy(busy_o[4]), .full(full_o[4]), .fifo_level(lvl[4]));
    uart_tx_fifo #(.DATA_BITS(5), .PARITY("NONE"), .STOP_BIT(1), .CLKS_PER_BIT(3), .FIFO_DEPTH(4)) u5 (
        .clk(clk), .rst(rst), .tx_data(data[5][4:0]), .tx_rdy(rdy[5]), .tx_ack(ack[5]),
        .tx(tx_o[5]), .busy(busy_o[5]), .full(full_o[5]), .fifo_level(lvl[5]));

    // ---------------- model ----------------
    // q holds queued words; line holds the tx level still to be driven, one entry per clock.
    int q    [N][$];
    bit line [N][$];
    bit m_ack [N];

    function automatic void push_frame(int i, int w);
        bit bits[$];
        int p;
        p = 0;
        bits.push_back(1'b0);
        for (int b = 0; b < DB[i]; b++) begin
            bits.push_back(w[b]);
            p = p ^ ((w >> b) & 1);
        end
        if (PM[i] == 1) bits.push_back(p == 0);
        if (PM[i] == 2) bits.push_back(p == 1);
        for (int s = 0; s < SB[i]; s++) bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int c = 0; c < CPB[i]; c++) line[i].push_back(bits[k]);
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        bit acc;
        bit can_pop;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                q[i].delete();
                line[i].delete();
                m_ack[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                acc     = rdy[i] && !m_ack[i] && (q[i].size() < DEPTH);
                can_pop = (line[i].size() <= 1);
                if (line[i].size() > 0) void'(line[i].pop_front());
                if (can_pop && (q[i].size() > 0)) push_frame(i, q[i].pop_front());
                if (acc) q[i].push_back(int'(data[i]) & ((1 << DB[i]) - 1));
                m_ack[i] <= acc;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input int idx, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s[%0d] got %0h expected %0h at %0t", nm, idx, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < N; i++) begin
            check("tx", i, int'(tx_o[i]), (line[i].size() > 0) ? int'(line[i][0]) : 1);
            check("busy", i, int'(busy_o[i]), int'(line[i].size() > 0));
            check("ack", i, int'(ack[i]), int'(m_ack[i]));
            check("level", i, int'(lvl[i]), q[i].size());
            check("full", i, int'(full_o[i]), int'(q[i].size() == DEPTH));
        end
    endtask

    // Offer one word and wait (bounded) for its ack, then drop tx_rdy.
    task automatic send(input int i, input int w, input int budget);
        int n;
        data[i] = 9'(w);
        rdy[i]  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[i] && (n < budget));
        check("ack_seen", i, int'(ack[i]), 1);
        rdy[i] = 1'b0;
    endtask

    // Record n tx samples (first sample ends up as MSB) and count busy over n+3 cycles.
    task automatic capture(input int i, input int n, output logic [31:0] bits, output int busy_cnt);
        bits = '0;
        busy_cnt = 0;
        for (int k = 0; k < n + 3; k++) begin
            @(negedge clk);
            if (k < n) bits = {bits[30:0], tx_o[i]};
            if (busy_o[i]) busy_cnt++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] bits;
        int          bcnt;
        logic [95:0] stream;
        logic [11:0] frame;
        bit          busy_all;
        int          n;
        int          acks;
        int          cyc;
        int          ack1_cyc;
        int          ack6_cyc;
        int          idle_hi;

        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            rdy[i]  = 1'b0;
            data[i] = '0;
        end

        fork
            forever begin
                @(negedge clk);
                compare_all();
            end
        join_none

        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check("rst_tx", i, int'(tx_o[i]), 1);
            check("rst_busy", i, int'(busy_o[i]), 0);
            check("rst_ack", i, int'(ack[i]), 0);
            check("rst_level", i, int'(lvl[i]), 0);
            check("rst_full", i, int'(full_o[i]), 0);
        end
        #2 rst = 1'b0;
        @(negedge clk);

        // Test 1: ODD parity, 0x01
        send(0, 'h01, 10);
        capture(0, 11, bits, bcnt);
        check("t1_bits", 0, int'(bits), 'b01000000001);
        check("t1_busy", 0, bcnt, 11);

        // Test 2: 0x03 with ODD, EVEN and NONE parity
        send(0, 'h03, 10);
        capture(0, 11, bits, bcnt);
        check("t2_odd", 0, int'(bits), 'b01100000011);
        send(1, 'h03, 10);
        capture(1, 11, bits, bcnt);
        check("t2_even", 1, int'(bits), 'b01100000001);
        send(2, 'h03, 10);
        capture(2, 10, bits, bcnt);
        check("t2_none", 2, int'(bits), 'b0110000001);
        check("t2_none_busy", 2, bcnt, 10);

        // Test 3: 8 words, two stop bits, back-to-back frames
        fork
            begin
                for (int k = 1; k <= 8; k++) send(3, k, 60);
            end
            begin
                n = 0;
                while ((tx_o[3] !== 1'b0) && (n < 20)) begin
                    @(negedge clk);
                    n++;
                end
                check("t3_start", 3, int'(tx_o[3]), 0);
                busy_all = 1'b1;
                stream   = '0;
                for (int k = 0; k < 96; k++) begin
                    if (k > 0) @(negedge clk);
                    stream[k] = tx_o[3];
                    if (!busy_o[3]) busy_all = 1'b0;
                end
                for (int f = 0; f < 8; f++) begin
                    frame = stream[f*12 +: 12];
                    check("t3_startbit", f, int'(frame[0]), 0);
                    check("t3_data", f, int'(frame[8:1]), f + 1);
                    check("t3_parity", f, int'(frame[9]), int'(~^frame[8:1]));
                    check("t3_stop", f, int'(frame[11:10]), 3);
                end
                check("t3_no_gap", 3, int'(busy_all), 1);
                @(negedge clk);
                check("t3_idle_after", 3, int'(busy_o[3]), 0);
            end
        join

        // Test 4: continuous producer into a 16-clock-per-bit line
        data[4] = 9'h001;
        rdy[4]  = 1'b1;
        acks = 0;
        cyc = 0;
        ack1_cyc = -1;
        ack6_cyc = -1;
        while ((acks < 6) && (cyc < 400)) begin
            @(negedge clk);
            cyc++;
            if (ack[4]) begin
                acks++;
                if (acks == 1) ack1_cyc = cyc;
                if (acks == 5) begin
                    check("t4_full", 4, int'(full_o[4]), 1);
                    check("t4_level4", 4, int'(lvl[4]), 4);
                end
                if (acks == 6) ack6_cyc = cyc;
                data[4] = 9'(acks + 1);
            end
        end
        rdy[4] = 1'b0;
        check("t4_acks", 4, acks, 6);
        check("t4_ack6_delay", 4, ack6_cyc - ack1_cyc, 162);
        check("t4_level_after", 4, int'(lvl[4]), 4);

        // Test 5: 5 data bits, 3 clocks per bit, 0x15
        send(5, 'h15, 10);
        capture(5, 21, bits, bcnt);
        check("t5_bits", 5, int'(bits), 'b000111000111000111111);
        check("t5_busy", 5, bcnt, 21);

        // Test 6: reset during frame 2 data with two words queued
        send(0, 'hA1, 10);
        send(0, 'hA2, 10);
        send(0, 'hA3, 10);
        send(0, 'hA4, 10);
        repeat (9) @(negedge clk);
        check("t6_level_pre", 0, int'(lvl[0]), 2);
        check("t6_busy_pre", 0, int'(busy_o[0]), 1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_tx", 0, int'(tx_o[0]), 1);
        check("t6_rst_level", 0, int'(lvl[0]), 0);
        check("t6_rst_busy", 0, int'(busy_o[0]), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        idle_hi = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (tx_o[0] && !busy_o[0]) idle_hi++;
        end
        check("t6_idle", 0, idle_hi, 20);
        send(0, 'h5A, 10);
        capture(0, 11, bits, bcnt);
        check("t6_bits", 0, int'(bits), 'b00101101011);
        check("t6_busy", 0, bcnt, 11);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
